// File: rtl/vram_write_arbiter_if.sv
// CPU write, fill-engine and VRAM port signals of the VRAM write arbiter.
// The slave modport is the arbiter side and the master modport is the driver side.
interface vram_write_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              cpu_valid;
    logic              cpu_ready;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_data;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] fill_len;
    logic [DATA_W-1:0] fill_data;
    logic              fill_busy;

    logic              video_enable;
    logic [ADDR_W-1:0] rd_address;
    logic [ADDR_W-1:0] vram_address;
    logic              w_enable;
    logic [DATA_W-1:0] w_data;

    modport slave (
        input  cpu_valid, cpu_address, cpu_data,
        input  fill_start, fill_base, fill_len, fill_data,
        input  video_enable, rd_address,
        output cpu_ready, fill_busy, vram_address, w_enable, w_data
    );

    modport master (
        output cpu_valid, cpu_address, cpu_data,
        output fill_start, fill_base, fill_len, fill_data,
        output video_enable, rd_address,
        input  cpu_ready, fill_busy, vram_address, w_enable, w_data
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Shares the single VRAM port between display reads, buffered CPU byte writes and a block-fill engine.
// Writes go out only during blanking. The CPU FIFO always wins over the fill engine.
module vram_write_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    vram_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_t;

    logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;

    logic              cpu_ready, push, pop, fifo_empty, fill_we;
    logic [ADDR_W-1:0] vram_address;
    logic              w_enable;
    logic [DATA_W-1:0] w_data;

    // cpu_ready depends on the registered count only, so a pop never opens it in the same cycle.
    assign cpu_ready  = (count_q < CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.cpu_valid && cpu_ready;
    assign pop        = !bus.video_enable && !fifo_empty;
    assign fill_we    = !bus.video_enable && fifo_empty && (state_q == FILL);

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = bus.cpu_address;
            mem_data_d[wr_ptr_q] = bus.cpu_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fill_ptr_d  = fill_ptr_q;
        remaining_d = remaining_q;
        fill_data_d = fill_data_q;
        case (state_q)
            IDLE: begin
                if (bus.fill_start && (bus.fill_len != '0)) begin
                    state_d     = FILL;
                    fill_ptr_d  = bus.fill_base;
                    remaining_d = bus.fill_len;
                    fill_data_d = bus.fill_data;
                end
            end
            FILL: begin
                if (fill_we) begin
                    fill_ptr_d  = fill_ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == ADDR_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vram_address = bus.rd_address;
        w_enable     = 1'b0;
        w_data       = '0;
        if (pop) begin
            vram_address = mem_addr_q[rd_ptr_q];
            w_data       = mem_data_q[rd_ptr_q];
            w_enable     = 1'b1;
        end else if (fill_we) begin
            vram_address = fill_ptr_q;
            w_data       = fill_data_q;
            w_enable     = 1'b1;
        end
    end

    assign bus.cpu_ready    = cpu_ready;
    assign bus.fill_busy    = (state_q == FILL);
    assign bus.vram_address = vram_address;
    assign bus.w_enable     = w_enable;
    assign bus.w_data       = w_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            fill_ptr_q  <= '0;
            remaining_q <= '0;
            fill_data_q <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            fill_ptr_q  <= fill_ptr_d;
            remaining_q <= remaining_d;
            fill_data_q <= fill_data_d;
        end
    end
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: CPU FIFO path, display priority, fill engine and async reset.
module tb_vram_write_arbiter;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam logic [AW-1:0] RD = 20'h12345;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    vram_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cpu_ready); end
        checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.w_enable); end
        checks++; if (bus.w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", bus.w_data); end
        checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.fill_busy); end
        checks++; if (bus.vram_address !== RD) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.vram_address, RD); end
        step;
        rst = 1'b1;
        step;
    endtask

    task automatic test_single_write;
        bus.cpu_valid = 1'b1; bus.cpu_address = 20'h00010; bus.cpu_data = 8'hA5;
        #1;
        checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL single_pre_we: got %b want 0", bus.w_enable); end
        step;
        bus.cpu_valid = 1'b0;
        checks++; if (bus.w_enable !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", bus.w_enable); end
        checks++; if (bus.vram_address !== 20'h00010) begin errors++; $display("FAIL single_addr: got %h want 00010", bus.vram_address); end
        checks++; if (bus.w_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", bus.w_data); end
        step;
        checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL single_post_we: got %b want 0", bus.w_enable); end
        checks++; if (bus.vram_address !== RD) begin errors++; $display("FAIL single_post_addr: got %h want %h", bus.vram_address, RD); end
    endtask

    task automatic test_fifo_full;
        bus.video_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_valid = 1'b1; bus.cpu_address = 20'h00100 + 20'(i); bus.cpu_data = 8'h10 + 8'(i);
            #1;
            checks++; if (bus.cpu_ready !== (i < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, bus.cpu_ready, (i < 4)); end
            checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL full_we_blocked[%0d]: got %b want 0", i, bus.w_enable); end
            checks++; if (bus.vram_address !== RD) begin errors++; $display("FAIL full_display_addr[%0d]: got %h want %h", i, bus.vram_address, RD); end
            step;
        end
        bus.cpu_valid = 1'b0;
        bus.video_enable = 1'b0;
        #1;
        checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", bus.cpu_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.w_enable !== 1'b1) begin errors++; $display("FAIL drain_we[%0d]: got %b want 1", i, bus.w_enable); end
            checks++; if (bus.vram_address !== 20'h00100 + 20'(i)) begin errors++; $display("FAIL drain_addr[%0d]: got %h want %h", i, bus.vram_address, 20'h00100 + 20'(i)); end
            checks++; if (bus.w_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.w_data, 8'h10 + 8'(i)); end
            step;
        end
        checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL drain_done_we: got %b want 0", bus.w_enable); end
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL drain_done_ready: got %b want 1", bus.cpu_ready); end
    endtask

    task automatic test_fill_wrap;
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 20'hFFFFE; exp_addr[1] = 20'hFFFFF; exp_addr[2] = 20'h00000; exp_addr[3] = 20'h00001;
        bus.fill_start = 1'b1; bus.fill_base = 20'hFFFFE; bus.fill_len = 20'd4; bus.fill_data = 8'h3C;
        #1;
        checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL wrap_pre_busy: got %b want 0", bus.fill_busy); end
        step;
        bus.fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.fill_busy !== 1'b1) begin errors++; $display("FAIL wrap_busy[%0d]: got %b want 1", i, bus.fill_busy); end
            checks++; if (bus.w_enable !== 1'b1) begin errors++; $display("FAIL wrap_we[%0d]: got %b want 1", i, bus.w_enable); end
            checks++; if (bus.vram_address !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, bus.vram_address, exp_addr[i]); end
            checks++; if (bus.w_data !== 8'h3C) begin errors++; $display("FAIL wrap_data[%0d]: got %h want 3c", i, bus.w_data); end
            step;
        end
        checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL wrap_done_busy: got %b want 0", bus.fill_busy); end
        checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL wrap_done_we: got %b want 0", bus.w_enable); end
    endtask

    task automatic test_fill_cpu_insert;
        bus.fill_start = 1'b1; bus.fill_base = 20'h00200; bus.fill_len = 20'd4; bus.fill_data = 8'h77;
        step;
        bus.fill_start = 1'b0;
        checks++; if (bus.vram_address !== 20'h00200) begin errors++; $display("FAIL ins_fill0: got %h want 00200", bus.vram_address); end
        step;
        bus.cpu_valid = 1'b1; bus.cpu_address = 20'h00300; bus.cpu_data = 8'h99;
        #1;
        checks++; if (bus.vram_address !== 20'h00201) begin errors++; $display("FAIL ins_fill1: got %h want 00201", bus.vram_address); end
        step;
        bus.cpu_valid = 1'b0;
        checks++; if (bus.vram_address !== 20'h00300 || bus.w_data !== 8'h99 || bus.w_enable !== 1'b1) begin
            errors++; $display("FAIL ins_cpu: got addr=%h data=%h we=%b want addr=00300 data=99 we=1", bus.vram_address, bus.w_data, bus.w_enable);
        end
        checks++; if (bus.fill_busy !== 1'b1) begin errors++; $display("FAIL ins_busy: got %b want 1", bus.fill_busy); end
        step;
        checks++; if (bus.vram_address !== 20'h00202 || bus.w_data !== 8'h77) begin errors++; $display("FAIL ins_fill2: got addr=%h data=%h want addr=00202 data=77", bus.vram_address, bus.w_data); end
        step;
        checks++; if (bus.vram_address !== 20'h00203) begin errors++; $display("FAIL ins_fill3: got %h want 00203", bus.vram_address); end
        step;
        checks++; if (bus.fill_busy !== 1'b0 || bus.w_enable !== 1'b0) begin errors++; $display("FAIL ins_done: got busy=%b we=%b want busy=0 we=0", bus.fill_busy, bus.w_enable); end
    endtask

    task automatic test_fill_len0_restart;
        int nwr = 0;
        bus.fill_start = 1'b1; bus.fill_base = 20'h00400; bus.fill_len = 20'd0; bus.fill_data = 8'hEE;
        step;
        bus.fill_start = 1'b0;
        checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", bus.fill_busy); end
        checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL len0_we: got %b want 0", bus.w_enable); end
        bus.fill_start = 1'b1; bus.fill_base = 20'h00500; bus.fill_len = 20'd3; bus.fill_data = 8'h11;
        step;
        bus.fill_start = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 0) begin
                bus.fill_start = 1'b1; bus.fill_base = 20'h00600; bus.fill_len = 20'd5; bus.fill_data = 8'h22;
            end
            #1;
            if (bus.w_enable === 1'b1) begin
                checks++; if (bus.vram_address !== 20'h00500 + 20'(nwr) || bus.w_data !== 8'h11) begin
                    errors++; $display("FAIL restart_write[%0d]: got addr=%h data=%h want addr=%h data=11", nwr, bus.vram_address, bus.w_data, 20'h00500 + 20'(nwr));
                end
                nwr++;
            end
            step;
            bus.fill_start = 1'b0;
        end
        checks++; if (nwr !== 3) begin errors++; $display("FAIL restart_count: got %0d want 3", nwr); end
        checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b want 0", bus.fill_busy); end
    endtask

    task automatic test_reset_mid;
        bus.video_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cpu_valid = 1'b1; bus.cpu_address = 20'h00800 + 20'(i); bus.cpu_data = 8'h50 + 8'(i);
            step;
        end
        bus.cpu_valid = 1'b0;
        bus.fill_start = 1'b1; bus.fill_base = 20'h00700; bus.fill_len = 20'd8; bus.fill_data = 8'h66;
        step;
        bus.fill_start = 1'b0;
        bus.video_enable = 1'b0;
        #1;
        checks++; if (bus.w_enable !== 1'b1 || bus.vram_address !== 20'h00800) begin errors++; $display("FAIL mid_pre_write: got we=%b addr=%h want we=1 addr=00800", bus.w_enable, bus.vram_address); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", bus.cpu_ready); end
        checks++; if (bus.w_enable !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b want 0", bus.w_enable); end
        checks++; if (bus.w_data !== 8'h00) begin errors++; $display("FAIL mid_rst_wdata: got %h want 00", bus.w_data); end
        checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.fill_busy); end
        checks++; if (bus.vram_address !== RD) begin errors++; $display("FAIL mid_rst_addr: got %h want %h", bus.vram_address, RD); end
        step;
        step;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step;
            checks++; if (bus.w_enable !== 1'b0 || bus.cpu_ready !== 1'b1 || bus.fill_busy !== 1'b0) begin
                errors++; $display("FAIL post_rst[%0d]: got we=%b ready=%b busy=%b want we=0 ready=1 busy=0", i, bus.w_enable, bus.cpu_ready, bus.fill_busy);
            end
        end
    endtask

    initial begin
        bus.cpu_valid = 1'b0; bus.cpu_address = '0; bus.cpu_data = '0;
        bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_len = '0; bus.fill_data = '0;
        bus.video_enable = 1'b0; bus.rd_address = RD;
        test_reset;
        test_single_write;
        test_fifo_full;
        test_fill_wrap;
        test_fill_cpu_insert;
        test_fill_len0_restart;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
